// File: rtl/adam_axil_pkg.sv
// Shared types for the AXI-Lite initiator: FSM state encoding and AXI response codes.
package adam_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WAIT_B,
        RD,
        WAIT_R,
        PAUSED
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/adam_axil_mst.sv
// Single-outstanding AXI-Lite initiator bridging a req/gnt memory port.
// Define ADAM_AXIL_MST_ALIGN_CHECK_EN to reject misaligned requests locally.
module adam_axil_mst
    import adam_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  pause_req,
    output logic                  pause_ack,

    input  logic                  req_valid,
    output logic                  req_gnt,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [STRB_WIDTH-1:0] req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic [ADDR_WIDTH-1:0] aw_addr,
    output logic [2:0]            aw_prot,
    output logic                  aw_valid,
    input  logic                  aw_ready,

    output logic [DATA_WIDTH-1:0] w_data,
    output logic [STRB_WIDTH-1:0] w_strb,
    output logic                  w_valid,
    input  logic                  w_ready,

    input  logic [1:0]            b_resp,
    input  logic                  b_valid,
    output logic                  b_ready,

    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [2:0]            ar_prot,
    output logic                  ar_valid,
    input  logic                  ar_ready,

    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_valid,
    output logic                  r_ready
);

`ifdef ADAM_AXIL_MST_ALIGN_CHECK_EN
    localparam int unsigned OFF_W =
        (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 1;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [STRB_WIDTH-1:0] be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  aw_done;
    logic                  w_done;

    logic accept;
    logic misalign;
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_addr = addr_q;
    assign ar_addr = addr_q;
    assign aw_prot = PROT;
    assign ar_prot = PROT;
    assign w_data  = wdata_q;
    assign w_strb  = be_q;

    always_comb begin
        req_gnt  = rst_n && (state == IDLE) && !pause_req;
        accept   = req_valid && req_gnt;
        aw_hs    = aw_valid && aw_ready;
        w_hs     = w_valid && w_ready;
        b_hs     = b_valid && b_ready;
        ar_hs    = ar_valid && ar_ready;
        r_hs     = r_valid && r_ready;
        aw_fin   = aw_done || aw_hs;
        w_fin    = w_done || w_hs;
        misalign = 1'b0;
`ifdef ADAM_AXIL_MST_ALIGN_CHECK_EN
        misalign = req_addr[OFF_W-1:0] != '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            pause_ack <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (accept && misalign) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (accept) begin
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        if (req_we) begin
                            state    <= WR;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            aw_done  <= 1'b0;
                            w_done   <= 1'b0;
                        end else begin
                            state    <= RD;
                            ar_valid <= 1'b1;
                        end
                    end else if (pause_req) begin
                        state     <= PAUSED;
                        pause_ack <= 1'b1;
                    end
                end
                WR: begin
                    // AW and W complete independently, in any order
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state   <= WAIT_B;
                        b_ready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_hs) begin
                        state     <= IDLE;
                        b_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= b_resp != RESP_OKAY;
                    end
                end
                RD: begin
                    if (ar_hs) begin
                        state    <= WAIT_R;
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                    end
                end
                WAIT_R: begin
                    if (r_hs) begin
                        state     <= IDLE;
                        r_ready   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= r_data;
                        rsp_err   <= r_resp != RESP_OKAY;
                    end
                end
                PAUSED: begin
                    if (!pause_req) begin
                        state     <= IDLE;
                        pause_ack <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_axil_mst.sv
// Bench for adam_axil_mst: transaction-level model plus an AXI-Lite slave
// with programmable delays; directed scenarios followed by random traffic.
module tb_adam_axil_mst;
    import adam_axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pause_req, pause_ack;
    logic        req_valid, req_gnt, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid, aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid, w_ready;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid, ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid, r_ready;

    always #5 clk = ~clk;

    adam_axil_mst dut (
        .clk(clk), .rst_n(rst_n),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .req_valid(req_valid), .req_gnt(req_gnt),
        .req_we(req_we), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .aw_addr(aw_addr), .aw_prot(aw_prot),
        .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_prot(ar_prot),
        .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // transaction-level model of the initiator
    bit          m_open, m_we, m_aw, m_w, m_ar, m_paused;
    bit          m_rsp_due, m_rsp_err;
    logic [31:0] m_addr, m_wdata, m_rsp_rdata;
    logic [3:0]  m_be;

    // requester intent
    bit          want_valid, want_we, want_pause, rand_mode;
    logic [31:0] want_addr, want_wdata;
    logic [3:0]  want_be;

    // slave state
    int          d_aw, d_w, d_ar, d_b, d_r;
    int          c_aw, c_w, c_ar, s_bc, s_rc;
    bit          s_aw, s_w, s_bp, s_rp;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_waddr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    int          force_resp = -1;
    logic [31:0] mem [64];

    // event log
    int          n_aw, n_w, n_rsp, first_ack_cyc;
    logic        last_err;
    logic [31:0] last_rdata;
    int          acc_cyc[$];
    int          rsp_cyc[$];

    task automatic chk(input string name,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     name, cyc, got, exp);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        int r;
        if (force_resp >= 0) return force_resp[1:0];
        if (!rand_mode) return RESP_OKAY;
        r = $urandom_range(0, 9);
        if (r < 6) return RESP_OKAY;
        if (r < 8) return RESP_SLVERR;
        return RESP_DECERR;
    endfunction

    task automatic reset_model();
        m_open = 0; m_we = 0; m_aw = 0; m_w = 0; m_ar = 0;
        m_paused = 0; m_rsp_due = 0; m_rsp_err = 0;
        m_rsp_rdata = '0;
        s_aw = 0; s_w = 0; s_bp = 0; s_rp = 0;
        c_aw = 0; c_w = 0; c_ar = 0; s_bc = 0; s_rc = 0;
    endtask

    task automatic new_rand_req();
        want_valid = 1;
        want_we    = 1'($urandom_range(0, 1));
        want_addr  = {24'h0, 8'($urandom)};
        if ($urandom_range(0, 3) != 0) want_addr[1:0] = 2'b00;
        want_be    = 4'($urandom);
        want_wdata = $urandom;
    endtask

    task automatic step();
        bit acc, exp_gnt, nxt_paused, misal;
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        @(negedge clk);
        cyc++;
        // registered outputs against the model
        chk("aw_valid", aw_valid, m_open && m_we && !m_aw);
        chk("w_valid", w_valid, m_open && m_we && !m_w);
        chk("b_ready", b_ready, m_open && m_we && m_aw && m_w);
        chk("ar_valid", ar_valid, m_open && !m_we && !m_ar);
        chk("r_ready", r_ready, m_open && !m_we && m_ar);
        chk("rsp_valid", rsp_valid, m_rsp_due);
        chk("pause_ack", pause_ack, m_paused);
        if (m_rsp_due) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err", rsp_err, m_rsp_err);
        end
        if (aw_valid) begin
            chk("aw_addr", aw_addr, m_addr);
            chk("aw_prot", aw_prot, 0);
        end
        if (w_valid) begin
            chk("w_data", w_data, m_wdata);
            chk("w_strb", w_strb, m_be);
        end
        if (ar_valid) begin
            chk("ar_addr", ar_addr, m_addr);
            chk("ar_prot", ar_prot, 0);
        end
        if (aw_valid) n_aw++;
        if (w_valid) n_w++;
        if (rsp_valid) begin
            n_rsp++;
            rsp_cyc.push_back(cyc);
            last_err   = rsp_err;
            last_rdata = rsp_rdata;
        end
        if (pause_ack && first_ack_cyc < 0) first_ack_cyc = cyc;

        // slave response side
        aw_ready = aw_valid && (c_aw >= d_aw);
        w_ready  = w_valid && (c_w >= d_w);
        ar_ready = ar_valid && (c_ar >= d_ar);
        b_valid  = s_bp && (s_bc == 0);
        b_resp   = s_bresp;
        r_valid  = s_rp && (s_rc == 0);
        r_resp   = s_rresp;
        r_data   = s_rdata;

        // requester side
        if (rand_mode) begin
            if (!want_valid && $urandom_range(0, 2) == 0)
                new_rand_req();
            if ($urandom_range(0, 49) == 0) want_pause = !want_pause;
        end
        req_valid = want_valid;
        req_we    = want_we;
        req_addr  = want_addr;
        req_be    = want_be;
        req_wdata = want_wdata;
        pause_req = want_pause;
        #1;

        exp_gnt = rst_n && !m_open && !m_paused && !pause_req;
        chk("req_gnt", req_gnt, exp_gnt);
        if (!rst_n) begin
            reset_model();
            return;
        end
        acc   = req_valid && exp_gnt;
        aw_hs = aw_valid && aw_ready;
        w_hs  = w_valid && w_ready;
        b_hs  = b_valid && b_ready;
        ar_hs = ar_valid && ar_ready;
        r_hs  = r_valid && r_ready;

        // model update
        nxt_paused = m_paused;
        if (m_paused && !pause_req) nxt_paused = 0;
        else if (!m_paused && !m_open && pause_req) nxt_paused = 1;
        m_rsp_due = 0;
        if (m_open && m_we) begin
            if (aw_hs) m_aw = 1;
            if (w_hs) m_w = 1;
            if (b_hs) begin
                m_open = 0;
                m_rsp_due = 1;
                m_rsp_err = b_resp != RESP_OKAY;
                m_rsp_rdata = '0;
            end
        end else if (m_open) begin
            if (ar_hs) m_ar = 1;
            if (r_hs) begin
                m_open = 0;
                m_rsp_due = 1;
                m_rsp_err = r_resp != RESP_OKAY;
                m_rsp_rdata = r_data;
            end
        end
        if (acc) begin
            acc_cyc.push_back(cyc);
            misal = 0;
`ifdef ADAM_AXIL_MST_ALIGN_CHECK_EN
            misal = req_addr[1:0] != 2'b00;
`endif
            if (misal) begin
                m_rsp_due = 1;
                m_rsp_err = 1;
                m_rsp_rdata = '0;
            end else begin
                m_open = 1; m_we = req_we;
                m_aw = 0; m_w = 0; m_ar = 0;
                m_addr = req_addr; m_be = req_be;
                m_wdata = req_wdata;
            end
            want_valid = 0;
        end
        m_paused = nxt_paused;

        // slave update
        if (aw_valid && !aw_ready) c_aw++;
        if (w_valid && !w_ready) c_w++;
        if (ar_valid && !ar_ready) c_ar++;
        if (aw_hs) begin
            c_aw = 0; s_aw = 1; s_waddr = aw_addr;
            if (rand_mode) d_aw = $urandom_range(0, 3);
        end
        if (w_hs) begin
            c_w = 0; s_w = 1; s_wdata = w_data; s_wstrb = w_strb;
            if (rand_mode) d_w = $urandom_range(0, 3);
        end
        if (ar_hs) begin
            c_ar = 0; s_rp = 1; s_rc = d_r;
            s_rdata = mem[ar_addr[7:2]];
            s_rresp = pick_resp();
            if (rand_mode) begin
                d_ar = $urandom_range(0, 3);
                d_r = $urandom_range(0, 3);
            end
        end else if (r_hs) begin
            s_rp = 0;
        end else if (s_rp && s_rc > 0) begin
            s_rc--;
        end
        if (b_hs) s_bp = 0;
        else if (s_bp && s_bc > 0) s_bc--;
        if (s_aw && s_w && !s_bp) begin
            for (int b = 0; b < 4; b++)
                if (s_wstrb[b])
                    mem[s_waddr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
            s_aw = 0; s_w = 0; s_bp = 1; s_bc = d_b;
            s_bresp = pick_resp();
            if (rand_mode) d_b = $urandom_range(0, 3);
        end
    endtask

    task automatic issue(input bit we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
        want_valid = 1; want_we = we; want_addr = addr;
        want_be = be; want_wdata = wd;
    endtask

    task automatic wait_rsp(input string name, input int target);
        for (int i = 0; i < 60 && n_rsp < target; i++) step();
        chk(name, n_rsp, target);
    endtask

    initial begin
        int n0;
        rst_n = 0;
        {pause_req, req_valid, req_we, aw_ready, w_ready} = '0;
        {b_valid, ar_ready, r_valid} = '0;
        {req_addr, req_wdata, r_data} = '0;
        {req_be, b_resp, r_resp} = '0;
        {want_valid, want_we, want_pause, rand_mode} = '0;
        want_addr = '0; want_wdata = '0; want_be = '0;
        {d_aw, d_w, d_ar, d_b, d_r} = '0;
        n_aw = 0; n_w = 0; n_rsp = 0; first_ack_cyc = -1;
        last_err = 0; last_rdata = '0;
        s_bresp = '0; s_rresp = '0; s_rdata = '0;
        s_waddr = '0; s_wdata = '0; s_wstrb = '0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        reset_model();
        repeat (3) step();
        rst_n = 1;
        step();
        chk("reset_gnt", req_gnt, 1);
        chk("reset_rsp", rsp_valid, 0);

        // write with W delayed three cycles
        n_aw = 0; n_w = 0; n_rsp = 0;
        d_w = 3;
        issue(1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF);
        wait_rsp("t1_rsp", 1);
        repeat (2) step();
        chk("t1_aw_cycles", n_aw, 1);
        chk("t1_w_cycles", n_w, 4);
        chk("t1_rsp_count", n_rsp, 1);
        chk("t1_err", last_err, 0);
        chk("t1_mem", mem[32'h1000 >> 2 & 63], 32'hDEAD_BEEF);
        d_w = 0;

        // read answered with SLVERR
        mem[16] = 32'h1234_5678;
        force_resp = 2;
        n_rsp = 0;
        issue(0, 32'h0000_0040, 4'h0, 32'h0);
        wait_rsp("t2_rsp", 1);
        chk("t2_rdata", last_rdata, 32'h1234_5678);
        chk("t2_err", last_err, 1);
        force_resp = -1;

        // back-to-back write then read, zero-wait slave
        acc_cyc.delete(); rsp_cyc.delete(); n_rsp = 0;
        issue(1, 32'h0000_0020, 4'h3, 32'hCAFE_F00D);
        for (int i = 0; i < 20 && acc_cyc.size() < 1; i++) step();
        issue(0, 32'h0000_0020, 4'h0, 32'h0);
        wait_rsp("t3_rsp", 2);
        chk("t3_acc_count", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2 && rsp_cyc.size() == 2) begin
            chk("t3_rsp1_lat", rsp_cyc[0] - acc_cyc[0], 3);
            chk("t3_gnt2_lat", acc_cyc[1] - acc_cyc[0], 3);
            chk("t3_rsp2_lat", rsp_cyc[1] - acc_cyc[0], 6);
            chk("t3_rdata", last_rdata, 32'h0000_F00D);
        end

        // pause raised while waiting on a slow B
        rsp_cyc.delete(); n_rsp = 0; first_ack_cyc = -1;
        d_b = 5;
        issue(1, 32'h0000_0030, 4'hF, 32'h5555_AAAA);
        for (int i = 0; i < 20 && !(m_open && m_aw && m_w); i++)
            step();
        want_pause = 1;
        for (int i = 0; i < 30 && first_ack_cyc < 0; i++) step();
        chk("t4_rsp_count", n_rsp, 1);
        if (rsp_cyc.size() == 1)
            chk("t4_ack_after_rsp", first_ack_cyc - rsp_cyc[0], 1);
        n0 = acc_cyc.size();
        issue(0, 32'h0000_0030, 4'h0, 32'h0);
        repeat (4) step();
        chk("t4_gnt_held", req_gnt, 0);
        chk("t4_no_acc", acc_cyc.size(), n0);
        chk("t4_ack_held", pause_ack, 1);
        want_pause = 0;
        for (int i = 0; i < 20 && acc_cyc.size() == n0; i++) step();
        chk("t4_resume_acc", acc_cyc.size(), n0 + 1);
        wait_rsp("t4_rd_rsp", 2);
        chk("t4_rdata", last_rdata, 32'h5555_AAAA);
        d_b = 0;

        // reset while waiting on R
        d_r = 10;
        issue(0, 32'h0000_0080, 4'h0, 32'h0);
        for (int i = 0; i < 20 && !(m_open && m_ar); i++) step();
        step();
        chk("t5_r_ready_pre", r_ready, 1);
        n0 = n_rsp;
        #2;
        rst_n = 0;
        reset_model();
        #1;
        chk("t5_ar_valid", ar_valid, 0);
        chk("t5_r_ready", r_ready, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_gnt_rst", req_gnt, 0);
        repeat (2) step();
        rst_n = 1;
        d_r = 0;
        step();
        chk("t5_gnt_after", req_gnt, 1);
        repeat (12) step();
        chk("t5_no_stale_rsp", n_rsp, n0);

`ifdef ADAM_AXIL_MST_ALIGN_CHECK_EN
        acc_cyc.delete(); rsp_cyc.delete();
        n_aw = 0; n_w = 0; n_rsp = 0;
        issue(1, 32'h0000_1002, 4'hF, 32'h0BAD_0BAD);
        wait_rsp("t6_rsp", 1);
        repeat (3) step();
        chk("t6_no_aw", n_aw, 0);
        chk("t6_no_w", n_w, 0);
        chk("t6_err", last_err, 1);
        if (acc_cyc.size() == 1 && rsp_cyc.size() == 1)
            chk("t6_lat", rsp_cyc[0] - acc_cyc[0], 1);
`endif

        // random traffic
        rand_mode = 1;
        repeat (3000) step();
        rand_mode = 0;
        want_pause = 0;
        for (int i = 0; i < 100 && want_valid; i++) step();
        repeat (30) step();
        chk("drain_idle", m_open, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
